// File: rtl/boot_up_sequencer.sv
// Boot/splash controller: debounced KEY or HID Enter starts a timed fade-out,
// after which boot_up is raised until the game logic reports game over.
`timescale 1ns/1ps
module boot_up_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned FADE_FRAMES     = 60,
   parameter int unsigned ANIM_DIV        = 8,
   parameter int unsigned NUM_ANIM        = 4,
   parameter logic [7:0]  START_KEY       = 8'h28
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_start_n,
   input  logic [7:0] keycode,
   input  logic       frame_tick,
   input  logic       game_over,
   output logic       boot_up,
   output logic       splash_active,
   output logic [3:0] splash_frame,
   output logic [7:0] fade_level
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1);
   localparam logic [7:0]      ANIM_LAST  = 8'(ANIM_DIV - 1);
   localparam logic [7:0]      FADE_LAST  = 8'(FADE_FRAMES - 1);
   localparam logic [3:0]      FRAME_LAST = 4'(NUM_ANIM - 1);

   typedef enum logic [1:0] {
      ST_SPLASH = 2'd0,
      ST_FADE   = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   logic            sync1_q;
   logic            btn_s_q;
   logic            btn_db_q, btn_db_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            btn_press_q, btn_press_d;
   logic            key_hit_q;
   logic            key_hit_s;
   logic            key_press_s;
   logic            start_req_s;

   state_t          state_q, state_d;
   logic            boot_up_q, boot_up_d;
   logic            splash_active_q, splash_active_d;
   logic [3:0]      splash_frame_q, splash_frame_d;
   logic [7:0]      fade_level_q, fade_level_d;
   logic [7:0]      anim_cnt_q, anim_cnt_d;

   // Debounce: the new level is accepted only after DEBOUNCE_CYCLES differing samples in a row.
   always_comb begin
      btn_db_d = btn_db_q;
      db_cnt_d = '0;
      if (btn_s_q != btn_db_q) begin
         if (db_cnt_q == DB_LAST) begin
            btn_db_d = btn_s_q;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
         end
      end else begin
         db_cnt_d = '0;
      end
   end

   assign btn_press_d = btn_db_q & ~btn_db_d;
   assign key_hit_s   = (keycode == START_KEY);
   assign key_press_s = key_hit_s & ~key_hit_q;
   assign start_req_s = btn_press_q | key_press_s;

   // Input synchronizer, debounce and edge-detect registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q     <= 1'b1;
         btn_s_q     <= 1'b1;
         btn_db_q    <= 1'b1;
         db_cnt_q    <= '0;
         btn_press_q <= 1'b0;
         key_hit_q   <= 1'b0;
      end else begin
         sync1_q     <= key_start_n;
         btn_s_q     <= sync1_q;
         btn_db_q    <= btn_db_d;
         db_cnt_q    <= db_cnt_d;
         btn_press_q <= btn_press_d;
         key_hit_q   <= key_hit_s;
      end
   end

   // Next state and registered outputs; illegal encodings fall back to a clean splash.
   always_comb begin
      state_d         = state_q;
      boot_up_d       = boot_up_q;
      splash_active_d = splash_active_q;
      splash_frame_d  = splash_frame_q;
      fade_level_d    = fade_level_q;
      anim_cnt_d      = anim_cnt_q;
      case (state_q)
         ST_SPLASH: begin
            if (start_req_s) begin
               state_d      = ST_FADE;
               fade_level_d = 8'd0;
            end else if (frame_tick) begin
               if (anim_cnt_q == ANIM_LAST) begin
                  anim_cnt_d     = 8'd0;
                  splash_frame_d = (splash_frame_q == FRAME_LAST) ? 4'd0 : splash_frame_q + 4'd1;
               end else begin
                  anim_cnt_d = anim_cnt_q + 8'd1;
               end
            end else begin
               state_d = ST_SPLASH;
            end
         end
         ST_FADE: begin
            if (frame_tick) begin
               if (fade_level_q == FADE_LAST) begin
                  state_d         = ST_RUN;
                  boot_up_d       = 1'b1;
                  splash_active_d = 1'b0;
                  fade_level_d    = 8'd0;
               end else begin
                  fade_level_d = fade_level_q + 8'd1;
               end
            end else begin
               state_d = ST_FADE;
            end
         end
         ST_RUN: begin
            if (game_over) begin
               state_d         = ST_SPLASH;
               boot_up_d       = 1'b0;
               splash_active_d = 1'b1;
               splash_frame_d  = 4'd0;
               anim_cnt_d      = 8'd0;
               fade_level_d    = 8'd0;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d         = ST_SPLASH;
            boot_up_d       = 1'b0;
            splash_active_d = 1'b1;
            splash_frame_d  = 4'd0;
            anim_cnt_d      = 8'd0;
            fade_level_d    = 8'd0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_SPLASH;
         boot_up_q       <= 1'b0;
         splash_active_q <= 1'b1;
         splash_frame_q  <= 4'd0;
         fade_level_q    <= 8'd0;
         anim_cnt_q      <= 8'd0;
      end else begin
         state_q         <= state_d;
         boot_up_q       <= boot_up_d;
         splash_active_q <= splash_active_d;
         splash_frame_q  <= splash_frame_d;
         fade_level_q    <= fade_level_d;
         anim_cnt_q      <= anim_cnt_d;
      end
   end

   assign boot_up       = boot_up_q;
   assign splash_active = splash_active_q;
   assign splash_frame  = splash_frame_q;
   assign fade_level    = fade_level_q;

endmodule

// File: tb/tb_boot_up_sequencer.sv
// Scoreboard bench for boot_up_sequencer: a counting reference model pushes the
// expected outputs every clock, and a separate monitor pops and compares them.
`timescale 1ns/1ps
module tb_boot_up_sequencer;

   localparam int DEB   = 4;
   localparam int FADEN = 3;
   localparam int ADIV  = 2;
   localparam int NANIM = 4;

   typedef struct packed {
      logic       boot;
      logic       sa;
      logic [3:0] frame;
      logic [7:0] fade;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       key_start_n = 1'b1;
   logic [7:0] keycode = 8'h00;
   logic       frame_tick = 1'b0;
   logic       game_over = 1'b0;
   logic       boot_up;
   logic       splash_active;
   logic [3:0] splash_frame;
   logic [7:0] fade_level;

   int   total = 0;
   int   bad = 0;
   bit   running = 1'b0;
   exp_t exp_q[$];

   // Reference model: phases named as strings, animation derived from a tick count.
   string m_phase;
   int    m_splash_ticks, m_fade_ticks;
   bit    m_key_hist[2];
   bit    m_db;
   int    m_diff_run;
   bit    m_press_pend, m_prev_hit;

   boot_up_sequencer #(
      .DEBOUNCE_CYCLES(DEB), .FADE_FRAMES(FADEN), .ANIM_DIV(ADIV),
      .NUM_ANIM(NANIM), .START_KEY(8'h28)
   ) dut (
      .clk(clk), .reset(reset), .key_start_n(key_start_n), .keycode(keycode),
      .frame_tick(frame_tick), .game_over(game_over), .boot_up(boot_up),
      .splash_active(splash_active), .splash_frame(splash_frame), .fade_level(fade_level)
   );

   always #5 clk = ~clk;

   function automatic void model_init();
      m_phase        = "splash";
      m_splash_ticks = 0;
      m_fade_ticks   = 0;
      m_key_hist[0]  = 1'b1;
      m_key_hist[1]  = 1'b1;
      m_db           = 1'b1;
      m_diff_run     = 0;
      m_press_pend   = 1'b0;
      m_prev_hit     = 1'b0;
   endfunction

   function automatic void model_step();
      bit hit, start, new_press;
      if (reset) begin
         model_init();
         return;
      end
      hit        = (keycode == 8'h28);
      start      = m_press_pend || (hit && !m_prev_hit);
      m_prev_hit = hit;
      if (m_phase == "splash") begin
         if (start) begin
            m_phase      = "fade";
            m_fade_ticks = 0;
         end else if (frame_tick) begin
            m_splash_ticks++;
         end
      end else if (m_phase == "fade") begin
         if (frame_tick) begin
            m_fade_ticks++;
            if (m_fade_ticks == FADEN) begin
               m_phase      = "run";
               m_fade_ticks = 0;
            end
         end
      end else begin
         if (game_over) begin
            m_phase        = "splash";
            m_splash_ticks = 0;
         end
      end
      new_press = 1'b0;
      if (m_key_hist[1] != m_db) begin
         m_diff_run++;
         if (m_diff_run == DEB) begin
            m_db       = m_key_hist[1];
            m_diff_run = 0;
            new_press  = !m_db;
         end
      end else begin
         m_diff_run = 0;
      end
      m_press_pend  = new_press;
      m_key_hist[1] = m_key_hist[0];
      m_key_hist[0] = key_start_n;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.boot  = (m_phase == "run");
      e.sa    = (m_phase != "run");
      e.frame = 4'((m_splash_ticks / ADIV) % NANIM);
      e.fade  = (m_phase == "fade") ? 8'(m_fade_ticks) : 8'd0;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
      end
   endtask

   // Monitor: the DUT presents a new registered output every clock.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("boot_up", {7'd0, boot_up}, {7'd0, e.boot});
         chk("splash_active", {7'd0, splash_active}, {7'd0, e.sa});
         chk("splash_frame", {4'd0, splash_frame}, {4'd0, e.frame});
         chk("fade_level", fade_level, e.fade);
      end else if (running) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end
   end

   task automatic cyc();
      @(posedge clk);
      model_step();
      exp_q.push_back(model_out());
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   initial begin
      model_init();
      running = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(2);
      for (int i = 0; i < 9; i++) begin
         tick();
         idle(2);
      end
      key_start_n = 1'b0; idle(3); key_start_n = 1'b1; idle(10);
      key_start_n = 1'b0; idle(10); key_start_n = 1'b1; idle(10);
      for (int i = 0; i < 3; i++) begin
         tick();
         idle(3);
      end
      game_over = 1'b1; cyc(); game_over = 1'b0; idle(3);
      keycode = 8'h28; idle(20); keycode = 8'h00; idle(2);
      for (int i = 0; i < 3; i++) begin
         tick();
         idle(1);
      end
      keycode = 8'h28; idle(5); keycode = 8'h00; idle(3);
      game_over = 1'b1; cyc(); game_over = 1'b0; idle(2);
      keycode = 8'h28; cyc(); keycode = 8'h00; idle(2);
      tick(); idle(1);
      reset = 1'b1; cyc(); reset = 1'b0; idle(4);
      // start and tick together: the transition must win
      keycode = 8'h28; frame_tick = 1'b1; cyc(); frame_tick = 1'b0; keycode = 8'h00; idle(2);
      reset = 1'b1; cyc(); reset = 1'b0; idle(2);
      for (int i = 0; i < 2000; i++) begin
         frame_tick = ($urandom_range(0, 3) == 0);
         game_over  = ($urandom_range(0, 29) == 0);
         reset      = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 11) == 0) key_start_n = ~key_start_n;
         case ($urandom_range(0, 39))
            0, 1:    keycode = 8'h28;
            2:       keycode = 8'($urandom_range(1, 255));
            3, 4:    keycode = 8'h00;
            default: keycode = keycode;
         endcase
         cyc();
      end
      frame_tick = 1'b0; game_over = 1'b0; reset = 1'b0;
      idle(3);
      running = 1'b0;
      @(posedge clk); #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
